// File: rtl/palette_lut_engine_if.sv
// palette_lut_engine_if: signal bundle between a pixel/host source and the
// palette engine.
//   master modport: drives the lookup, palette-write, frame, fade and
//                   cycling controls, and receives the coloured pixel stream
//                   and status.
//   slave modport:  the engine side of the same bundle.
// Clock and reset are plain ports on the engine and are not part of the bundle.
interface palette_lut_engine_if #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int BANKS = 2
);
    localparam int BK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                  pix_valid_in;
    logic [IDX_W-1:0]      index;
    logic [BK_W-1:0]       bank_sel;
    logic                  wr_en;
    logic [BK_W-1:0]       wr_bank;
    logic [IDX_W-1:0]      wr_addr;
    logic [3*CH_W-1:0]     wr_data;
    logic                  frame_tick;
    logic                  fade_start;
    logic                  fade_dir;
    logic                  cycle_en;
    logic [IDX_W-1:0]      cycle_lo;
    logic [IDX_W-1:0]      cycle_hi;
    logic [CH_W-1:0]       red;
    logic [CH_W-1:0]       green;
    logic [CH_W-1:0]       blue;
    logic                  pix_valid_out;
    logic                  ready;
    logic                  fade_busy;
    logic [CH_W:0]         fade_level;

    modport master (
        output pix_valid_in, index, bank_sel,
        output wr_en, wr_bank, wr_addr, wr_data,
        output frame_tick, fade_start, fade_dir,
        output cycle_en, cycle_lo, cycle_hi,
        input  red, green, blue, pix_valid_out, ready, fade_busy, fade_level
    );

    modport slave (
        input  pix_valid_in, index, bank_sel,
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  frame_tick, fade_start, fade_dir,
        input  cycle_en, cycle_lo, cycle_hi,
        output red, green, blue, pix_valid_out, ready, fade_busy, fade_level
    );
endinterface

// File: rtl/palette_lut_engine.sv
// palette_lut_engine: banked colour palette with colour cycling and
// frame-stepped fade to/from black.
// Ports:
//   Clk      - sole clock, rising edge
//   Reset_n  - synchronous active-low reset
//   bus      - slave side of palette_lut_engine_if:
//              pix_valid_in/index/bank_sel  lookup request (2-cycle latency)
//              wr_en/wr_bank/wr_addr/wr_data palette entry write ({R,G,B})
//              frame_tick                    per-frame pulse (cycling, fade)
//              fade_start/fade_dir           fade command (0 out, 1 in)
//              cycle_en/cycle_lo/cycle_hi    colour-cycling index range
//              red/green/blue/pix_valid_out  faded pixel output
//              ready/fade_busy/fade_level    status
module palette_lut_engine #(
    parameter int IDX_W = 4,
    parameter int CH_W  = 4,
    parameter int BANKS = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    palette_lut_engine_if.slave bus
);
    localparam int DEPTH  = 1 << IDX_W;
    localparam int DATA_W = 3 * CH_W;

    localparam logic [CH_W:0]      LEVEL_FULL = {1'b1, {CH_W{1'b0}}};
    localparam logic [CH_W:0]      LEVEL_ZERO = {(CH_W + 1){1'b0}};
    localparam logic [CH_W:0]      LEVEL_ONE  = (CH_W + 1)'(1'b1);
    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = {IDX_W{1'b1}};
    localparam logic [DATA_W-1:0]  DATA_ZERO  = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } fade_state_e;

    // Scale one channel by the fade level: floor(ch * level / 2^CH_W).
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [CH_W:0]   level);
        logic [2*CH_W:0] prod;
        prod = {{(CH_W + 1){1'b0}}, ch} * {{CH_W{1'b0}}, level};
        return CH_W'(prod >> CH_W);
    endfunction

    // Rotate an index inside [lo, hi] by off; indices outside the range, or
    // an empty/disabled range, pass straight through. The span can reach
    // 2^IDX_W, so the modular sum is carried one bit wider than an index.
    function automatic logic [IDX_W-1:0] eff_index(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] lo,
                                                   input logic [IDX_W-1:0] hi,
                                                   input logic [IDX_W-1:0] off,
                                                   input logic             en);
        logic [IDX_W:0]   span;
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] res;
        span = {1'b0, hi} - {1'b0, lo} + {{IDX_W{1'b0}}, 1'b1};
        sum  = {1'b0, idx} - {1'b0, lo} + {1'b0, off};
        // idx-lo and off are both below span, so one subtraction suffices.
        if (sum >= span) begin
            sum = sum - span;
        end else begin
            sum = sum;
        end
        if (en && (lo < hi) && (idx >= lo) && (idx <= hi)) begin
            res = lo + IDX_W'(sum);
        end else begin
            res = idx;
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_q [BANKS][DEPTH];

    logic [IDX_W-1:0]  init_addr_q, init_addr_d;
    logic              ready_q, ready_d;
    logic [IDX_W-1:0]  off_q, off_d;
    fade_state_e       state_q, state_d;
    logic [CH_W:0]     level_q, level_d;
    logic              busy_q;
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_rgb_q, out_rgb_d;
    logic [IDX_W-1:0]  eff_idx_s;

    // INIT sweep: one address per cycle until the last one is cleared.
    always_comb begin
        init_addr_d = init_addr_q;
        ready_d     = ready_q;
        if (!ready_q) begin
            init_addr_d = init_addr_q + IDX_ONE;
            if (init_addr_q == IDX_LAST) begin
                ready_d = 1'b1;
            end else begin
                ready_d = 1'b0;
            end
        end else begin
            init_addr_d = init_addr_q;
            ready_d     = 1'b1;
        end
    end

    // Colour-cycling offset: held at 0 unless cycling a non-empty range.
    always_comb begin
        off_d = off_q;
        if (!bus.cycle_en || !(bus.cycle_lo < bus.cycle_hi)) begin
            off_d = IDX_ZERO;
        end else if (bus.frame_tick) begin
            if (off_q >= (bus.cycle_hi - bus.cycle_lo)) begin
                off_d = IDX_ZERO;
            end else begin
                off_d = off_q + IDX_ONE;
            end
        end else begin
            off_d = off_q;
        end
    end

    // Fade FSM next state and level.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fade_start) begin
                    state_d = bus.fade_dir ? ST_FADE_IN : ST_FADE_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FADE_OUT: begin
                if (bus.frame_tick) begin
                    if (level_q == LEVEL_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q - LEVEL_ONE;
                        state_d = (level_q == LEVEL_ONE) ? ST_IDLE : ST_FADE_OUT;
                    end
                end else begin
                    state_d = ST_FADE_OUT;
                end
            end
            ST_FADE_IN: begin
                if (bus.frame_tick) begin
                    if (level_q >= LEVEL_FULL) begin
                        state_d = ST_IDLE;
                    end else begin
                        level_d = level_q + LEVEL_ONE;
                        state_d = (level_q == (LEVEL_FULL - LEVEL_ONE)) ? ST_IDLE : ST_FADE_IN;
                    end
                end else begin
                    state_d = ST_FADE_IN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = LEVEL_FULL;
            end
        endcase
    end

    // Stage 1 read: entries are forced to zero until INIT has finished.
    always_comb begin
        eff_idx_s = eff_index(bus.index, bus.cycle_lo, bus.cycle_hi, off_q, bus.cycle_en);
        if (ready_q) begin
            s1_data_d = mem_q[bus.bank_sel][eff_idx_s];
        end else begin
            s1_data_d = DATA_ZERO;
        end
    end

    // Stage 2: fade scaling with the current level; blank when not valid.
    always_comb begin
        out_rgb_d = DATA_ZERO;
        if (s1_valid_q) begin
            out_rgb_d = {scale_ch(s1_data_q[3*CH_W-1:2*CH_W], level_q),
                         scale_ch(s1_data_q[2*CH_W-1:CH_W],   level_q),
                         scale_ch(s1_data_q[CH_W-1:0],        level_q)};
        end else begin
            out_rgb_d = DATA_ZERO;
        end
    end

    // Palette storage: INIT clears all banks at one address per cycle;
    // afterwards the single host write port. Reads sample before this edge,
    // so a same-cycle write/lookup returns the old entry.
    always_ff @(posedge Clk) begin
        if (!ready_q) begin
            for (int b = 0; b < BANKS; b++) begin
                mem_q[b][init_addr_q] <= DATA_ZERO;
            end
        end else if (bus.wr_en && Reset_n) begin
            mem_q[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
        end else begin
            mem_q[bus.wr_bank][bus.wr_addr] <= mem_q[bus.wr_bank][bus.wr_addr];
        end
    end

    // Control state, pipeline and output registers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            init_addr_q <= IDX_ZERO;
            ready_q     <= 1'b0;
            off_q       <= IDX_ZERO;
            state_q     <= ST_IDLE;
            level_q     <= LEVEL_FULL;
            busy_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= DATA_ZERO;
            out_valid_q <= 1'b0;
            out_rgb_q   <= DATA_ZERO;
        end else begin
            init_addr_q <= init_addr_d;
            ready_q     <= ready_d;
            off_q       <= off_d;
            state_q     <= state_d;
            level_q     <= level_d;
            busy_q      <= (state_d != ST_IDLE);
            s1_valid_q  <= bus.pix_valid_in;
            s1_data_q   <= s1_data_d;
            out_valid_q <= s1_valid_q;
            out_rgb_q   <= out_rgb_d;
        end
    end

    assign bus.red           = out_rgb_q[3*CH_W-1:2*CH_W];
    assign bus.green         = out_rgb_q[2*CH_W-1:CH_W];
    assign bus.blue          = out_rgb_q[CH_W-1:0];
    assign bus.pix_valid_out = out_valid_q;
    assign bus.ready         = ready_q;
    assign bus.fade_busy     = busy_q;
    assign bus.fade_level    = level_q;
endmodule

// File: doc/palette_lut_engine.md
PALETTE_LUT_ENGINE -- requirements
Module: palette_lut_engine

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning palette index width (2^IDX_W entries per bank).
REQ-002 SHALL have parameter CH_W, default 4, meaning bits per colour channel.
REQ-003 SHALL have parameter BANKS, default 2, meaning number of independent palette banks (power of two, BK_W = max(1, log2 BANKS)).
REQ-004 SHALL have port Clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port Reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pix_valid_in  input  1  index/bank_sel qualify a lookup this cycle.
REQ-007 SHALL have port index  input  IDX_W  pixel palette index.
REQ-008 SHALL have port bank_sel  input  BK_W  bank used for the lookup.
REQ-009 SHALL have port wr_en  input  1  write one palette entry.
REQ-010 SHALL have port wr_bank  input  BK_W, wr_addr  input  IDX_W, wr_data  input  3*CH_W  write target and {R,G,B} value.
REQ-011 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-012 SHALL have port fade_start  input  1, fade_dir  input  1  (0 = fade to black, 1 = fade from black).
REQ-013 SHALL have port cycle_en  input  1, cycle_lo  input  IDX_W, cycle_hi  input  IDX_W  colour-cycling range.
REQ-014 SHALL have port red, green, blue  output  CH_W each  looked-up, faded colour.
REQ-015 SHALL have port pix_valid_out  output  1  red/green/blue valid.
REQ-016 SHALL have port ready  output  1, fade_busy  output  1, fade_level  output  CH_W+1.

Function
REQ-017 SHALL contain BANKS x 2^IDX_W entries of 3*CH_W bits, one write port and one read port.
REQ-018 SHALL on leaving reset enter INIT: clear one entry per cycle (all banks in parallel) to 0, addresses 0..2^IDX_W-1, ready=0; then ready=1 (INIT takes 2^IDX_W cycles, 16 at defaults).
REQ-019 SHALL ignore wr_en while ready=0; lookups during INIT produce pix_valid_out but colour 0.
REQ-020 SHALL have lookup latency exactly 2 cycles: pix_valid_out(t+2) = pix_valid_in(t), colour from index/bank_sel sampled at t; red/green/blue = 0 whenever pix_valid_out=0.
REQ-021 SHALL be read-first: a write and a lookup to the same bank/address in one cycle returns the old entry; the new value is visible to lookups issued the next cycle.
REQ-022 SHALL compute effective index when cycle_en=1, cycle_lo<cycle_hi and cycle_lo<=index<=cycle_hi as cycle_lo + ((index - cycle_lo + off) mod (cycle_hi - cycle_lo + 1)); otherwise effective index = index.
REQ-023 SHALL keep cycling offset off: reset 0; cleared to 0 whenever cycle_en=0; on frame_tick with cycle_en=1, off increments and wraps from (cycle_hi-cycle_lo) to 0.
REQ-024 SHALL scale each channel as out = (ch * fade_level) >> CH_W (floor, full-width product); fade_level=2^CH_W passes colour unchanged, 0 gives black.
REQ-025 SHALL implement fade FSM states IDLE, FADE_OUT, FADE_IN; fade_busy=1 outside IDLE.
REQ-026 SHALL in IDLE on fade_start move to FADE_OUT (dir 0) or FADE_IN (dir 1) without changing fade_level; fade_start while busy is ignored.
REQ-027 SHALL in FADE_OUT decrement fade_level on each frame_tick, returning to IDLE in the cycle it reaches 0; FADE_IN increments, returning to IDLE on reaching 2^CH_W; fade_level never leaves 0..2^CH_W.
REQ-028 SHALL in FADE_OUT/FADE_IN with level already at target return to IDLE on the next frame_tick without changing level.
REQ-029 SHALL sample fade_level for scaling in pipeline stage 2 (level change affects pixels emerging the cycle after the change).

Reset
REQ-030 SHALL on Reset_n=0 at a clock edge set red/green/blue=0, pix_valid_out=0, pipeline flushed, ready=0, fade FSM IDLE, fade_level=2^CH_W, fade_busy=0, off=0.
REQ-031 SHALL restart INIT from address 0 after any reset, including reset asserted mid-INIT or mid-fade.

Verification
REQ-032 Reset release -> ready=0 for 16 cycles then 1; lookup of any index -> 12'h000 with pix_valid_out 2 cycles later.
REQ-033 Write bank1 addr 3 = 12'h58E, lookup bank1 idx3 next cycle -> {5,8,E} at t+2; same-cycle write+lookup -> old value 000.
REQ-034 Entry {F,F,F}, fade_start dir 0, 8 frame_ticks -> fade_level 8, output {7,7,7}; 16 ticks -> {0,0,0}, fade_busy=0.
REQ-035 cycle_lo=4, cycle_hi=7, entries 4..7 distinct, cycle_en=1, 1 frame_tick -> index 7 returns entry 4, index 5 returns entry 6; 4 ticks -> identity; index 3 unaffected.
REQ-036 Reset_n=0 mid-FADE_IN (level 5) with pixels in flight -> next cycle outputs 0, level 16, IDLE, INIT restarts at address 0.
